// File: rtl/clk_rst_seq.sv
// clk_rst_seq: PLL-lock synchroniser, core reset sequencer and clock-enable
// generator for the 24 MHz clk domain.
//
// Configuration macro: CE_PAUSE_EN
//   When defined, pause=1 in RUN suppresses ce_cpu and freezes its divider phase.
//   When undefined, pause is unused and ce_cpu free-runs.
//
// Ports:
//   clk         in   24 MHz system clock
//   rst_n       in   async active-low reset
//   pll_locked  in   PLL lock, asynchronous to clk
//   pause       in   CPU pause request (CE_PAUSE_EN only)
//   rst_periph  out  active-high reset for video/sound/peripherals
//   rst_cpu     out  active-high reset for Z80 and bus logic
//   ce_pix      out  pixel enable, one cycle high every PIX_DIV cycles
//   ce_cpu      out  CPU enable, one cycle high every CPU_DIV cycles
//   ready       out  high in RUN
module clk_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 24000,
  parameter int CPU_DELAY   = 16,
  parameter int PIX_DIV     = 4,
  parameter int CPU_DIV     = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic pause,
  output logic rst_periph,
  output logic rst_cpu,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ready
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DLY_W  = (CPU_DELAY > 1)   ? $clog2(CPU_DELAY)   : 1;
  localparam int PIX_W  = $clog2(PIX_DIV);
  localparam int CPU_W  = $clog2(CPU_DIV);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(CPU_DELAY - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    PERIPH    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [DLY_W-1:0]       dly_cnt;
  logic [PIX_W-1:0]       pix_cnt;
  logic [CPU_W-1:0]       cpu_cnt;
  logic                   div_run;
  logic                   cpu_hold;

  // Lock synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // State register and sequencing counters; counters only advance while the
  // FSM stays in their state, so any exit (including loss of lock) clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
      dly_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == HOLD   && state_nxt == HOLD)   ? hold_cnt + 1'b1 : '0;
      dly_cnt  <= (state == PERIPH && state_nxt == PERIPH) ? dly_cnt + 1'b1  : '0;
    end
  end

  // Next state and state-decoded resets
  always_comb begin
    state_nxt  = state;
    rst_periph = 1'b1;
    rst_cpu    = 1'b1;
    ready      = 1'b0;
    if (!lock_s) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: state_nxt = HOLD;
        HOLD:      if (hold_cnt == HOLD_LAST) state_nxt = PERIPH;
        PERIPH:    if (dly_cnt == DLY_LAST)   state_nxt = RUN;
        RUN:       state_nxt = RUN;
        default:   state_nxt = WAIT_LOCK;
      endcase
    end
    case (state)
      PERIPH: rst_periph = 1'b0;
      RUN: begin
        rst_periph = 1'b0;
        rst_cpu    = 1'b0;
        ready      = 1'b1;
      end
      default: ;
    endcase
  end

  // Dividers run only while rst_periph is already low and will stay low, so
  // the first enable lands exactly DIV cycles after the fall and both enables
  // drop on the same edge that reasserts the resets.
  assign div_run = !rst_periph && (state_nxt == PERIPH || state_nxt == RUN);

`ifdef CE_PAUSE_EN
  assign cpu_hold = (state == RUN) && pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign cpu_hold     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      ce_pix  <= 1'b0;
    end else if (!div_run) begin
      pix_cnt <= '0;
      ce_pix  <= 1'b0;
    end else if (pix_cnt == PIX_LAST) begin
      pix_cnt <= '0;
      ce_pix  <= 1'b1;
    end else begin
      pix_cnt <= pix_cnt + 1'b1;
      ce_pix  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_cnt <= '0;
      ce_cpu  <= 1'b0;
    end else if (!div_run) begin
      cpu_cnt <= '0;
      ce_cpu  <= 1'b0;
    end else if (cpu_hold) begin
      ce_cpu  <= 1'b0;
    end else if (cpu_cnt == CPU_LAST) begin
      cpu_cnt <= '0;
      ce_cpu  <= 1'b1;
    end else begin
      cpu_cnt <= cpu_cnt + 1'b1;
      ce_cpu  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Testbench for clk_rst_seq: expected output edges (cycle numbers) are queued
// by the stimulus; a monitor pops and compares on every output edge.
module tb_clk_rst_seq;

  localparam int HOLD = 100;
  localparam int DLY  = 16;
  localparam int PIXD = 4;
  localparam int CPUD = 6;
`ifdef CE_PAUSE_EN
  localparam int PLEN = 20;
`else
  localparam int PLEN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, pll_locked, pause;
  logic rst_periph, rst_cpu, ce_pix, ce_cpu, ready;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  ev_t q_periph[$];
  ev_t q_cpu[$];
  ev_t q_ready[$];
  int  q_pix[$];
  int  q_ccpu[$];

  clk_rst_seq #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(HOLD),
    .CPU_DELAY  (DLY),
    .PIX_DIV    (PIXD),
    .CPU_DIV    (CPUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .pause     (pause),
    .rst_periph(rst_periph),
    .rst_cpu   (rst_cpu),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .ready     (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic chk_ev(input string name, input logic v, input int c, input ev_t e);
    n_total++;
    if (v === e.val && c == e.cyc) n_pass++;
    else $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                  name, v, c, e.val, e.cyc);
  endtask

  task automatic chk_idle(input string tag);
    chk_bit({tag, " rst_periph"}, rst_periph, 1'b1);
    chk_bit({tag, " rst_cpu"},    rst_cpu,    1'b1);
    chk_bit({tag, " ce_pix"},     ce_pix,     1'b0);
    chk_bit({tag, " ce_cpu"},     ce_cpu,     1'b0);
    chk_bit({tag, " ready"},      ready,      1'b0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ev(input int which, input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (which)
      0:       q_periph.push_back(e);
      1:       q_cpu.push_back(e);
      default: q_ready.push_back(e);
    endcase
  endtask

  // Enable pulses after rst_periph falls at edge t, up to edge stop; ce_cpu
  // pulses later than pause_at slip by the pause length when pausing is built in.
  task automatic push_ce(input int t, input int stop, input int pause_at);
    int e;
    for (int c = t + PIXD; c <= stop; c += PIXD) q_pix.push_back(c);
    for (int c = t + CPUD; c <= stop; c += CPUD) begin
      e = (c > pause_at) ? c + PLEN : c;
      if (e <= stop) q_ccpu.push_back(e);
    end
  endtask

  // Monitor
  initial begin
    logic p_per, p_cpu, p_rdy, p_pix, p_ccpu;
    ev_t  e;
    p_per = 1'b1; p_cpu = 1'b1; p_rdy = 1'b0; p_pix = 1'b0; p_ccpu = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_periph !== p_per) begin
        if (q_periph.size() == 0) chk("rst_periph unexpected edge", cyc, -1);
        else begin e = q_periph.pop_front(); chk_ev("rst_periph edge", rst_periph, cyc, e); end
      end
      if (rst_cpu !== p_cpu) begin
        if (q_cpu.size() == 0) chk("rst_cpu unexpected edge", cyc, -1);
        else begin e = q_cpu.pop_front(); chk_ev("rst_cpu edge", rst_cpu, cyc, e); end
      end
      if (ready !== p_rdy) begin
        if (q_ready.size() == 0) chk("ready unexpected edge", cyc, -1);
        else begin e = q_ready.pop_front(); chk_ev("ready edge", ready, cyc, e); end
      end
      if (ce_pix === 1'b1 && p_pix !== 1'b1) begin
        if (q_pix.size() == 0) chk("ce_pix unexpected pulse", cyc, -1);
        else chk("ce_pix pulse cycle", cyc, q_pix.pop_front());
      end
      if (ce_cpu === 1'b1 && p_ccpu !== 1'b1) begin
        if (q_ccpu.size() == 0) chk("ce_cpu unexpected pulse", cyc, -1);
        else chk("ce_cpu pulse cycle", cyc, q_ccpu.pop_front());
      end
      p_per = rst_periph; p_cpu = rst_cpu; p_rdy = ready; p_pix = ce_pix; p_ccpu = ce_cpu;
    end
  end

  // Stimulus
  initial begin
    int n0, n1, n2, t, p, l, n3, t3, r;
    ev_t e;
    rst_n = 1'b0; pll_locked = 1'b0; pause = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("in reset");
    rst_n = 1'b1;

    // No lock: stay idle
    wait_cyc(cyc + 40);
    chk_idle("no lock");

    // Lock with a glitch at HOLD cycle 50, then full sequence
    n0 = cyc;
    pll_locked = 1'b1;
    n1 = n0 + 3 + 50;
    n2 = n1 + 5;
    t  = n2 + 3 + HOLD;
    p  = t + 40;
    l  = t + 120;
    push_ev(0, t, 1'b0);
    push_ev(1, t + DLY, 1'b0);
    push_ev(2, t + DLY, 1'b1);
    push_ev(0, l + 3, 1'b1);
    push_ev(1, l + 3, 1'b1);
    push_ev(2, l + 3, 1'b0);
    push_ce(t, l + 2, p);
    wait_cyc(n1);
    pll_locked = 1'b0;
    wait_cyc(n2);
    pll_locked = 1'b1;
    wait_cyc(t - 1);
    chk_bit("rst_periph held before hold done", rst_periph, 1'b1);
    wait_cyc(t + DLY);
    chk_bit("ready in RUN", ready, 1'b1);
    wait_cyc(p);
    pause = 1'b1;
    wait_cyc(p + 20);
    pause = 1'b0;
    wait_cyc(l);
    pll_locked = 1'b0;
    wait_cyc(l + 3);
    chk_idle("lock lost");

    // Async reset during PERIPH
    wait_cyc(l + 20);
    n3 = cyc;
    pll_locked = 1'b1;
    t3 = n3 + 3 + HOLD;
    r  = t3 + 5;
    push_ev(0, t3, 1'b0);
    push_ev(0, r + 1, 1'b1);
    push_ce(t3, r, r);
    wait_cyc(r);
    #2 rst_n = 1'b0;
    #1 chk_idle("async reset");
    @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(cyc + 30);
    chk_idle("final");

    @(negedge clk);
    #1;
    while (q_periph.size() > 0) begin e = q_periph.pop_front(); chk("rst_periph missing edge", -1, e.cyc); end
    while (q_cpu.size() > 0)    begin e = q_cpu.pop_front();    chk("rst_cpu missing edge", -1, e.cyc); end
    while (q_ready.size() > 0)  begin e = q_ready.pop_front();  chk("ready missing edge", -1, e.cyc); end
    while (q_pix.size() > 0)  chk("ce_pix missing pulse", -1, q_pix.pop_front());
    while (q_ccpu.size() > 0) chk("ce_cpu missing pulse", -1, q_ccpu.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
